mc_controller: RTL and testbench

Multicycle ARM control unit: instruction decode, condition evaluation and a state machine that sequences fetch, decode, memory, execute and writeback over several cycles, so one ALU and one unified memory port can be shared. It replaces the single-cycle controller in the multicycle datapath. It holds the NZCV flag register. Parameters select memory wait-state handshaking and conditional execution.

---
 rtl/mc_controller.sv | 256 +++++++++++++++++++++++++
 tb/tb_mc_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: instruction decode, condition check, NZCV
// flag register and the fetch/decode/memory/execute/writeback sequencer.
//
// Parameters
//   WAIT_EN    1 = honour MemReady, 0 = memory always ready
//   COND_EN    1 = evaluate the condition field, 0 = always execute
// Ports
//   clk, reset          clock, synchronous active-high reset
//   Instr[19:0]         IR[31:12] (bit n here is IR bit n+12)
//   ALUFlags[3:0]       N,Z,C,V from the ALU this cycle
//   MemReady            memory access completes this cycle
//   PCWrite, IRWrite, RegWrite, MemWrite   write enables
//   AdrSrc              0 = PC, 1 = ALUOut
//   RegSrc, ImmSrc      register / immediate selects
//   ALUSrcA, ALUSrcB    ALU operand selects
//   ResultSrc           0 = ALUOut, 1 = ReadData, 2 = ALUResult
//   ALUControl, Shift   ALU operation, shifter path for MOV
//   carry               stored C flag
//   State               current state, for debug
module mc_controller #(
  parameter bit WAIT_EN = 1'b1,
  parameter bit COND_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [2:0]  ALUControl,
  output logic        Shift,
  output logic        carry,
  output logic [3:0]  State
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned FLAG_W  = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_ADC = 3'b101;
  localparam logic [2:0] ALU_MOV = 3'b110;

  state_t            state, state_nxt;
  logic [FLAG_W-1:0] flags, flags_nxt;

  // Instruction fields, named by their IR bit positions
  logic [3:0] cond;
  logic [1:0] op;
  logic       bit_i;
  logic [3:0] cmd;
  logic       bit_u;
  logic       bit_sl;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = Instr[19:16];  // IR[31:28]
  assign op        = Instr[15:14];  // IR[27:26]
  assign bit_i     = Instr[13];     // IR[25]
  assign cmd       = Instr[12:9];   // IR[24:21]
  assign bit_u     = Instr[11];     // IR[23]
  assign bit_sl    = Instr[8];      // IR[20], S for data processing, L for memory
  assign rd        = Instr[3:0];    // IR[15:12]
  assign unused_rn = ^Instr[7:4];

  logic ready;
  assign ready = WAIT_EN ? MemReady : 1'b1;

  // Condition evaluation against the stored flags
  logic cond_pass;
  logic cond_ex;
  logic fn, fz, fc, fv;

  always_comb begin
    {fn, fz, fc, fv} = flags;
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = fz;
      4'b0001: cond_pass = ~fz;
      4'b0010: cond_pass = fc;
      4'b0011: cond_pass = ~fc;
      4'b0100: cond_pass = fn;
      4'b0101: cond_pass = ~fn;
      4'b0110: cond_pass = fv;
      4'b0111: cond_pass = ~fv;
      4'b1000: cond_pass = fc & ~fz;
      4'b1001: cond_pass = ~fc | fz;
      4'b1010: cond_pass = (fn == fv);
      4'b1011: cond_pass = (fn != fv);
      4'b1100: cond_pass = ~fz & (fn == fv);
      4'b1101: cond_pass = fz | (fn != fv);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
    cond_ex = COND_EN ? cond_pass : 1'b1;
  end

  // Data-processing decode: ALU op, result suppression, flag request
  logic [2:0] dp_aluc;
  logic       dp_nowrite;
  logic       dp_shift;
  logic       dp_arith;
  logic       dp_setflags;

  always_comb begin
    dp_aluc    = ALU_ADD;
    dp_nowrite = 1'b0;
    dp_shift   = 1'b0;
    case (cmd)
      4'b0100: dp_aluc = ALU_ADD;
      4'b0010: dp_aluc = ALU_SUB;
      4'b0000: dp_aluc = ALU_AND;
      4'b1100: dp_aluc = ALU_ORR;
      4'b0001: dp_aluc = ALU_EOR;
      4'b0101: dp_aluc = ALU_ADC;
      4'b1101: begin dp_aluc = ALU_MOV; dp_shift = 1'b1; end
      4'b1010: begin dp_aluc = ALU_SUB; dp_nowrite = 1'b1; end
      4'b1000: begin dp_aluc = ALU_AND; dp_nowrite = 1'b1; end
      default: begin dp_aluc = ALU_ADD; dp_nowrite = 1'b1; end
    endcase
    dp_arith    = (dp_aluc == ALU_ADD) || (dp_aluc == ALU_SUB) || (dp_aluc == ALU_ADC);
    dp_setflags = bit_sl || (cmd == 4'b1010) || (cmd == 4'b1000);
  end

  // Next state, datapath selects and gated write enables
  logic reg_w, mem_w, branch, next_pc, ir_w, exec_st;

  always_comb begin
    state_nxt  = S_FETCH;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    next_pc    = 1'b0;
    ir_w       = 1'b0;
    exec_st    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = ALU_ADD;
    Shift      = 1'b0;

    case (state)
      S_FETCH: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_w      = ready;
        next_pc   = ready;
        state_nxt = ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (op)
          2'b01:   state_nxt = S_MEMADR;
          2'b00:   state_nxt = bit_i ? S_EXECI : S_EXECR;
          2'b10:   state_nxt = S_BRANCH;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB    = 2'b01;
        ALUControl = bit_u ? ALU_ADD : ALU_SUB;
        state_nxt  = bit_sl ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc    = 1'b1;
        state_nxt = ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc    = 1'b1;
        mem_w     = 1'b1;
        state_nxt = ready ? S_FETCH : S_MEMWR;
      end
      S_EXECR, S_EXECI: begin
        exec_st    = 1'b1;
        ALUSrcB    = (state == S_EXECI) ? 2'b01 : 2'b00;
        ALUControl = dp_aluc;
        Shift      = dp_shift;
        state_nxt  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w     = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase

    // NoWrite only applies to data-processing instructions
    RegWrite = ~reset & reg_w & cond_ex & ~((op == 2'b00) & dp_nowrite);
    MemWrite = ~reset & mem_w & cond_ex;
    IRWrite  = ~reset & ir_w;
    PCWrite  = ~reset & (next_pc | (branch & cond_ex) | (RegWrite & (rd == 4'hF)));

    // Logical ops keep the stored C and V
    flags_nxt = flags;
    if (exec_st && cond_ex && dp_setflags) begin
      flags_nxt = dp_arith ? ALUFlags : {ALUFlags[3:2], flags[1:0]};
    end
  end

  assign RegSrc = {(op == 2'b01) & ~bit_sl, (op == 2'b10)};
  assign ImmSrc = op;
  assign carry  = flags[1];
  assign State  = state;

  // State and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      flags <= '0;
    end else begin
      state <= state_nxt;
      flags <= flags_nxt;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: a cycle-by-cycle vector table for
// the instruction sequences, plus hand-written reset and COND_EN sequences.
// A second instance (WAIT_EN=0, COND_EN=0) shares the inputs.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;

  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, Shift, carry;
  logic [1:0] RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  logic       pcw_n, irw_n, regw_n, memw_n, adr_n, shift_n, carry_n;
  logic [1:0] regsrc_n, immsrc_n, srca_n, srcb_n, ress_n;
  logic [2:0] aluc_n;
  logic [3:0] state_n;

  mc_controller #(.WAIT_EN(1'b1), .COND_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
    .Shift(Shift), .carry(carry), .State(State)
  );

  mc_controller #(.WAIT_EN(1'b0), .COND_EN(1'b0)) dut_nc (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(pcw_n), .IRWrite(irw_n), .RegWrite(regw_n), .MemWrite(memw_n),
    .AdrSrc(adr_n), .RegSrc(regsrc_n), .ImmSrc(immsrc_n), .ALUSrcA(srca_n),
    .ALUSrcB(srcb_n), .ResultSrc(ress_n), .ALUControl(aluc_n),
    .Shift(shift_n), .carry(carry_n), .State(state_n)
  );

  always #5 clk = ~clk;

  // en  = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, Shift, carry}
  // sel = {ALUSrcA, ALUSrcB, ALUControl, ResultSrc}
  typedef struct packed {
    logic [19:0] instr;
    logic [3:0]  flg;
    logic        rdy;
    logic [3:0]  st;
    logic [6:0]  en;
    logic [8:0]  sel;
  } vec_t;

  localparam logic [19:0] I_ADD   = 20'hE0811;
  localparam logic [19:0] I_SUBS  = 20'hE2500;
  localparam logic [19:0] I_BEQ   = 20'h0A000;
  localparam logic [19:0] I_ADDS  = 20'hE0900;
  localparam logic [19:0] I_LDR   = 20'hE5902;
  localparam logic [19:0] I_STR   = 20'hE5802;
  localparam logic [19:0] I_UND   = 20'hEC000;
  localparam logic [19:0] I_STRD  = 20'hE5002;
  localparam logic [19:0] I_STREQ = 20'h05802;
  localparam logic [19:0] I_CMP   = 20'hE1500;
  localparam logic [19:0] I_TST   = 20'hE1100;
  localparam logic [19:0] I_BGE   = 20'hAA000;
  localparam logic [19:0] I_MOVPC = 20'hE1A0F;
  localparam logic [19:0] I_NVADD = 20'hF0811;

  localparam logic [8:0] SF  = 9'b01_10_000_10;  // fetch / decode
  localparam logic [8:0] S0  = 9'b00_00_000_00;  // RD1,RD2,ADD,ALUOut
  localparam logic [8:0] SIS = 9'b00_01_001_00;  // ExtImm, SUB
  localparam logic [8:0] SBR = 9'b00_01_000_10;  // branch target
  localparam logic [8:0] SMA = 9'b00_01_000_00;  // address, U=1
  localparam logic [8:0] SWB = 9'b00_00_000_01;  // ReadData writeback
  localparam logic [8:0] SRS = 9'b00_00_001_00;  // reg SUB
  localparam logic [8:0] SRA = 9'b00_00_010_00;  // reg AND
  localparam logic [8:0] SRM = 9'b00_00_110_00;  // MOV

  int n_chk  = 0;
  int n_pass = 0;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [19:0] i, input logic [3:0] f, input logic r);
    Instr = i; ALUFlags = f; MemReady = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Instruction sequences, one row per cycle
    vecs.push_back('{I_ADD,   4'hF, 1'b1, 4'd0, 7'b1100000, SF});
    vecs.push_back('{I_ADD,   4'hF, 1'b1, 4'd1, 7'b0000000, SF});
    vecs.push_back('{I_ADD,   4'hF, 1'b1, 4'd6, 7'b0000000, S0});
    vecs.push_back('{I_ADD,   4'hF, 1'b1, 4'd8, 7'b0010000, S0});
    vecs.push_back('{I_SUBS,  4'h4, 1'b1, 4'd0, 7'b1100000, SF});
    vecs.push_back('{I_SUBS,  4'h4, 1'b1, 4'd1, 7'b0000000, SF});
    vecs.push_back('{I_SUBS,  4'h4, 1'b1, 4'd7, 7'b0000000, SIS});
    vecs.push_back('{I_SUBS,  4'h4, 1'b1, 4'd8, 7'b0010000, S0});
    vecs.push_back('{I_BEQ,   4'h0, 1'b1, 4'd0, 7'b1100000, SF});
    vecs.push_back('{I_BEQ,   4'h0, 1'b1, 4'd1, 7'b0000000, SF});
    vecs.push_back('{I_BEQ,   4'h0, 1'b1, 4'd9, 7'b1000000, SBR});
    vecs.push_back('{I_ADDS,  4'h2, 1'b1, 4'd0, 7'b1100000, SF});
    vecs.push_back('{I_ADDS,  4'h2, 1'b1, 4'd1, 7'b0000000, SF});
    vecs.push_back('{I_ADDS,  4'h2, 1'b1, 4'd6, 7'b0000000, S0});
    vecs.push_back('{I_ADDS,  4'h2, 1'b1, 4'd8, 7'b0010001, S0});
    vecs.push_back('{I_BEQ,   4'h0, 1'b1, 4'd0, 7'b1100001, SF});
    vecs.push_back('{I_BEQ,   4'h0, 1'b1, 4'd1, 7'b0000001, SF});
    vecs.push_back('{I_BEQ,   4'h0, 1'b1, 4'd9, 7'b0000001, SBR});
    vecs.push_back('{I_LDR,   4'h0, 1'b1, 4'd0, 7'b1100001, SF});
    vecs.push_back('{I_LDR,   4'h0, 1'b1, 4'd1, 7'b0000001, SF});
    vecs.push_back('{I_LDR,   4'h0, 1'b1, 4'd2, 7'b0000001, SMA});
    vecs.push_back('{I_LDR,   4'h0, 1'b0, 4'd3, 7'b0000101, S0});
    vecs.push_back('{I_LDR,   4'h0, 1'b0, 4'd3, 7'b0000101, S0});
    vecs.push_back('{I_LDR,   4'h0, 1'b1, 4'd3, 7'b0000101, S0});
    vecs.push_back('{I_LDR,   4'h0, 1'b1, 4'd4, 7'b0010001, SWB});
    vecs.push_back('{I_STR,   4'h0, 1'b0, 4'd0, 7'b0000001, SF});
    vecs.push_back('{I_STR,   4'h0, 1'b1, 4'd0, 7'b1100001, SF});
    vecs.push_back('{I_STR,   4'h0, 1'b1, 4'd1, 7'b0000001, SF});
    vecs.push_back('{I_STR,   4'h0, 1'b1, 4'd2, 7'b0000001, SMA});
    vecs.push_back('{I_STR,   4'h0, 1'b0, 4'd5, 7'b0001101, S0});
    vecs.push_back('{I_STR,   4'h0, 1'b1, 4'd5, 7'b0001101, S0});
    vecs.push_back('{I_UND,   4'h0, 1'b1, 4'd0, 7'b1100001, SF});
    vecs.push_back('{I_UND,   4'h0, 1'b1, 4'd1, 7'b0000001, SF});
    vecs.push_back('{I_STRD,  4'h0, 1'b1, 4'd0, 7'b1100001, SF});
    vecs.push_back('{I_STRD,  4'h0, 1'b1, 4'd1, 7'b0000001, SF});
    vecs.push_back('{I_STRD,  4'h0, 1'b1, 4'd2, 7'b0000001, SIS});
    vecs.push_back('{I_STRD,  4'h0, 1'b1, 4'd5, 7'b0001101, S0});
    vecs.push_back('{I_STREQ, 4'h0, 1'b1, 4'd0, 7'b1100001, SF});
    vecs.push_back('{I_STREQ, 4'h0, 1'b1, 4'd1, 7'b0000001, SF});
    vecs.push_back('{I_STREQ, 4'h0, 1'b1, 4'd2, 7'b0000001, SMA});
    vecs.push_back('{I_STREQ, 4'h0, 1'b1, 4'd5, 7'b0000101, S0});
    vecs.push_back('{I_CMP,   4'h9, 1'b1, 4'd0, 7'b1100001, SF});
    vecs.push_back('{I_CMP,   4'h9, 1'b1, 4'd1, 7'b0000001, SF});
    vecs.push_back('{I_CMP,   4'h9, 1'b1, 4'd6, 7'b0000001, SRS});
    vecs.push_back('{I_CMP,   4'h9, 1'b1, 4'd8, 7'b0000000, S0});
    vecs.push_back('{I_TST,   4'h6, 1'b1, 4'd0, 7'b1100000, SF});
    vecs.push_back('{I_TST,   4'h6, 1'b1, 4'd1, 7'b0000000, SF});
    vecs.push_back('{I_TST,   4'h6, 1'b1, 4'd6, 7'b0000000, SRA});
    vecs.push_back('{I_TST,   4'h6, 1'b1, 4'd8, 7'b0000000, S0});
    vecs.push_back('{I_BGE,   4'h0, 1'b1, 4'd0, 7'b1100000, SF});
    vecs.push_back('{I_BGE,   4'h0, 1'b1, 4'd1, 7'b0000000, SF});
    vecs.push_back('{I_BGE,   4'h0, 1'b1, 4'd9, 7'b0000000, SBR});
    vecs.push_back('{I_BEQ,   4'h0, 1'b1, 4'd0, 7'b1100000, SF});
    vecs.push_back('{I_BEQ,   4'h0, 1'b1, 4'd1, 7'b0000000, SF});
    vecs.push_back('{I_BEQ,   4'h0, 1'b1, 4'd9, 7'b1000000, SBR});
    vecs.push_back('{I_MOVPC, 4'h0, 1'b1, 4'd0, 7'b1100000, SF});
    vecs.push_back('{I_MOVPC, 4'h0, 1'b1, 4'd1, 7'b0000000, SF});
    vecs.push_back('{I_MOVPC, 4'h0, 1'b1, 4'd6, 7'b0000010, SRM});
    vecs.push_back('{I_MOVPC, 4'h0, 1'b1, 4'd8, 7'b1010000, S0});

    // Reset: write enables forced low even in a ready FETCH
    reset = 1'b1;
    drive(I_ADD, 4'h0, 1'b1);
    tick();
    tick();
    chk("rst.state", 20'(State), 20'd0);
    chk("rst.pcwrite", 20'(PCWrite), 20'd0);
    chk("rst.irwrite", 20'(IRWrite), 20'd0);
    chk("rst.carry", 20'(carry), 20'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].instr, vecs[i].flg, vecs[i].rdy);
      chk($sformatf("v%0d.state", i),    20'(State),      20'(vecs[i].st));
      chk($sformatf("v%0d.pcwrite", i),  20'(PCWrite),    20'(vecs[i].en[6]));
      chk($sformatf("v%0d.irwrite", i),  20'(IRWrite),    20'(vecs[i].en[5]));
      chk($sformatf("v%0d.regwrite", i), 20'(RegWrite),   20'(vecs[i].en[4]));
      chk($sformatf("v%0d.memwrite", i), 20'(MemWrite),   20'(vecs[i].en[3]));
      chk($sformatf("v%0d.adrsrc", i),   20'(AdrSrc),     20'(vecs[i].en[2]));
      chk($sformatf("v%0d.shift", i),    20'(Shift),      20'(vecs[i].en[1]));
      chk($sformatf("v%0d.carry", i),    20'(carry),      20'(vecs[i].en[0]));
      chk($sformatf("v%0d.alusrca", i),  20'(ALUSrcA),    20'(vecs[i].sel[8:7]));
      chk($sformatf("v%0d.alusrcb", i),  20'(ALUSrcB),    20'(vecs[i].sel[6:5]));
      chk($sformatf("v%0d.aluctl", i),   20'(ALUControl), 20'(vecs[i].sel[4:2]));
      chk($sformatf("v%0d.resultsrc", i), 20'(ResultSrc), 20'(vecs[i].sel[1:0]));
      tick();
    end

    // Set C, then reset in the middle of a stalled store
    drive(I_ADDS, 4'h2, 1'b1);
    tick(); tick(); tick();
    chk("adds.carry", 20'(carry), 20'd1);
    tick();
    drive(I_STR, 4'h0, 1'b1);
    tick(); tick(); tick();
    drive(I_STR, 4'h0, 1'b0);
    chk("rstwr.state", 20'(State), 20'd5);
    chk("rstwr.memwrite", 20'(MemWrite), 20'd1);
    chk("rstwr.regsrc", 20'(RegSrc), 20'd2);
    chk("rstwr.immsrc", 20'(ImmSrc), 20'd1);
    reset = 1'b1;
    #1;
    chk("rstwr.memwrite_rst", 20'(MemWrite), 20'd0);
    drive(I_STR, 4'h0, 1'b1);
    tick();
    chk("rstwr.state_after", 20'(State), 20'd0);
    chk("rstwr.carry_after", 20'(carry), 20'd0);
    chk("rstwr.pcwrite_rst", 20'(PCWrite), 20'd0);
    chk("rstwr.irwrite_rst", 20'(IRWrite), 20'd0);

    // Never-coded ADD: executes only with conditions disabled
    reset = 1'b0;
    drive(I_NVADD, 4'h0, 1'b1);
    chk("nv.state_n", 20'(state_n), 20'd0);
    tick(); tick(); tick();
    chk("nv.state", 20'(State), 20'd8);
    chk("nv.state_nc", 20'(state_n), 20'd8);
    chk("nv.regwrite", 20'(RegWrite), 20'd0);
    chk("nv.regwrite_nc", 20'(regw_n), 20'd1);
    tick();
    drive(I_NVADD, 4'h0, 1'b0);
    chk("nowait.irwrite", 20'(IRWrite), 20'd0);
    chk("nowait.irwrite_nc", 20'(irw_n), 20'd1);
    chk("nowait.pcwrite_nc", 20'(pcw_n), 20'd1);
    tick();
    chk("nowait.state", 20'(State), 20'd0);
    chk("nowait.state_nc", 20'(state_n), 20'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
